// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM states and decode helpers for the multi-cycle ALU.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0, OP_OR    = 4'h1, OP_XOR   = 4'h2, OP_NOR   = 4'h3,
    OP_ADD   = 4'h4, OP_SUB   = 4'h5, OP_SLTU  = 4'h6, OP_SLL   = 4'h7,
    OP_SRL   = 4'h8, OP_SRA   = 4'h9, OP_SLT   = 4'hA, OP_MULLO = 4'hB,
    OP_MULHU = 4'hC, OP_DIVU  = 4'hD, OP_REMU  = 4'hE, OP_RSVD  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIN} alu_state_e;

  // Anything not explicitly iterative (including undefined codes) takes the single-cycle path.
  function automatic logic is_iter_op(input logic [3:0] op);
    case (op)
      OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      OP_DIVU, OP_REMU: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath, one step per cycle.
module alu_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SHW-1:0]   cnt,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  // hi/lo: product accumulator for mul, remainder/quotient shifters for div.
  logic [WIDTH-1:0] hi_q, lo_q, mc_q, rdiff;
  logic [WIDTH:0]   msum, rsh;
  logic             div_q, ge;
  logic [SHW-1:0]   cnt_q;

  assign cnt = cnt_q;

  // nxt_* are the values after the step taken this cycle, so the caller can
  // capture the final result on the same edge as the last step.
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    rsh   = {hi_q, lo_q[WIDTH-1]};
    ge    = rsh >= {1'b0, mc_q};
    rdiff = rsh[WIDTH-1:0] - mc_q;
    if (div_q) begin
      nxt_hi = ge ? rdiff : rsh[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = msum[WIDTH:1];
      nxt_lo = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mc_q  <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= is_div ? a : b;
      mc_q  <= is_div ? b : a;
      div_q <= is_div;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: start/busy/done handshake, registered result and flags.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF,
  output logic             DZ
);

  localparam int M = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic             rdy_q, dz_q, accept, iter_start, last_step, sub;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt, sh;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, iter_res, res, b_in;
  logic [WIDTH:0]   add_s;
  logic             sc_of, sc_cf;

  // rdy_q blocks a start coinciding with the first edge after reset release.
  assign accept     = (state_q == ST_IDLE) && start && rdy_q;
  assign iter_start = accept && is_iter_op(alu_op);
  assign last_step  = (state_q == ST_ITER) && (cnt == SHW'(WIDTH-1));
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_iter_op(alu_op) ? ST_ITER : ST_FIN;
      ST_ITER: if (last_step) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared WIDTH+1 adder: SUB feeds ~B with carry-in 1.
  assign sub   = (alu_op == OP_SUB);
  assign b_in  = sub ? ~B : B;
  assign add_s = {1'b0, A} + {1'b0, b_in} + {{WIDTH{1'b0}}, sub};
  assign sh    = A[SHW-1:0];

  always_comb begin
    res   = '0;
    sc_of = 1'b0;
    sc_cf = 1'b0;
    case (alu_op)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOR:  res = ~(A | B);
      OP_ADD, OP_SUB: begin
        res   = add_s[M:0];
        sc_of = A[M] ^ b_in[M] ^ add_s[M] ^ add_s[WIDTH];
        sc_cf = sub ? ~add_s[WIDTH] : add_s[WIDTH];
      end
      OP_SLTU: res = {{M{1'b0}}, A < B};
      OP_SLL:  res = B << sh;
      OP_SRL:  res = B >> sh;
      OP_SRA:  res = $signed(B) >>> sh;
      OP_SLT:  res = {{M{1'b0}}, $signed(A) < $signed(B)};
      default: res = '0;
    endcase
  end

  assign iter_res = (op_q == OP_MULLO || op_q == OP_DIVU) ? nxt_lo : nxt_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      op_q  <= '0;
      dz_q  <= 1'b0;
      F     <= '0;
      ZF    <= 1'b1;
      OF    <= 1'b0;
      CF    <= 1'b0;
      DZ    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (iter_start) begin
        op_q <= alu_op;
        dz_q <= is_div_op(alu_op) && (B == '0);
      end
      if (accept && !is_iter_op(alu_op)) begin
        F  <= res;
        ZF <= (res == '0);
        OF <= sc_of;
        CF <= sc_cf;
        DZ <= 1'b0;
      end else if (last_step) begin
        F  <= iter_res;
        ZF <= (iter_res == '0);
        OF <= 1'b0;
        CF <= 1'b0;
        DZ <= dz_q;
      end
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (iter_start),
    .step   (state_q == ST_ITER),
    .is_div (is_div_op(alu_op)),
    .a      (A),
    .b      (B),
    .cnt    (cnt),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Randomized + directed check of alu_mc against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [31:0] A = '0, B = '0, F;
  logic        busy, done, ZF, OF, CF, DZ;
  int          n_cmp = 0, n_err = 0;

  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .A(A), .B(B),
    .busy(busy), .done(done), .F(F), .ZF(ZF), .OF(OF), .CF(CF), .DZ(DZ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] f, output bit of, output bit cf,
                                 output bit dz, output int lat);
    longint signed   sa = longint'($signed(a)), sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a}, ub = {32'd0, b}, p;
    of = 0; cf = 0; dz = 0; lat = 1;
    case (op)
      4'h0: f = a & b;
      4'h1: f = a | b;
      4'h2: f = a ^ b;
      4'h3: f = ~(a | b);
      4'h4: begin
        p = ua + ub; f = p[31:0]; cf = p[32];
        of = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
      end
      4'h5: begin
        f = a - b; cf = (a < b);
        of = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
      end
      4'h6: f = (ua < ub) ? 32'd1 : 32'd0;
      4'h7: f = b << (a % 32);
      4'h8: f = b >> (a % 32);
      4'h9: begin p = 64'(sb / (64'sd1 << (a % 32)) - ((sb < 0 && sb % (64'sd1 << (a % 32)) != 0) ? 1 : 0)); f = p[31:0]; end
      4'hA: f = (sa < sb) ? 32'd1 : 32'd0;
      4'hB: begin p = ua * ub; f = p[31:0];  lat = 33; end
      4'hC: begin p = ua * ub; f = p[63:32]; lat = 33; end
      4'hD: begin f = (b == 0) ? 32'hFFFF_FFFF : a / b; dz = (b == 0); lat = 33; end
      4'hE: begin f = (b == 0) ? a : a % b;             dz = (b == 0); lat = 33; end
      default: f = 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit junk);
    logic [31:0] ef;
    bit eo, ec, ed, got;
    int el, lat;
    ref_op(op, a, b, ef, eo, ec, ed, el);
    @(negedge clk);
    alu_op = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; alu_op = 4'($urandom);
    lat = 0; got = 0;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      else start = junk && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    chk($sformatf("lat op%h", op), lat, el);
    chk($sformatf("F op%h %h,%h", op, a, b), F, ef);
    chk($sformatf("ZF op%h", op), ZF, ef == 0);
    chk($sformatf("OF op%h", op), OF, eo);
    chk($sformatf("CF op%h", op), CF, ec);
    chk($sformatf("DZ op%h", op), DZ, ed);
    @(negedge clk);
    chk("done one pulse", done, 0);
    chk("busy after done", busy, 0);
    chk("F held", F, ef);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst F", F, 0);
    chk("rst ZF", ZF, 1);
    chk("rst flags", {OF, CF, DZ}, 0);
    rst_n = 1'b1;

    run_op(4'h4, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'h5, 32'h0, 32'h1, 0);
    run_op(4'hA, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'h6, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'h9, 32'h4, 32'h8000_0000, 0);
    run_op(4'h8, 32'h4, 32'h8000_0000, 0);
    run_op(4'h7, 32'd32, 32'h1234_5678, 0);
    run_op(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(4'hD, 32'd100, 32'd7, 0);
    run_op(4'hE, 32'd100, 32'd7, 0);
    run_op(4'hD, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(4'hE, 32'd5, 32'd0, 0);
    run_op(4'hF, 32'h1, 32'h2, 0);
    run_op(4'h4, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'h5, 32'h8000_0000, 32'h1, 0);

    // Reset mid-iteration discards the op.
    @(negedge clk);
    alu_op = 4'hD; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst F", F, 0);
    chk("midrst ZF", ZF, 1);
    repeat (2) begin @(negedge clk); chk("midrst no done", done, 0); end
    alu_op = 4'h4; A = 32'd1; B = 32'd1; start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start at rst release ignored", busy, 0);
    repeat (40) begin @(negedge clk); chk("no done after rst", done, 0); end
    chk("F after rst", F, 0);
    run_op(4'hD, 32'd1000, 32'd3, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra % 40;
      run_op(4'($urandom_range(0, 15)), ra, rb, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
